// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: action encoding and default sizes.
package pc_pkg;

    localparam int PC_WIDTH_DEF = 8;
    localparam int PC_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        ACT_HOLD   = 3'd0,
        ACT_INC    = 3'd1,
        ACT_JUMP   = 3'd2,
        ACT_BRANCH = 3'd3,
        ACT_CALL   = 3'd4,
        ACT_RET    = 3'd5
    } pc_act_e;

endpackage

// File: rtl/pc_call_stack.sv
// Return-address LIFO for the sequencer. Rejected pushes/pops are flagged on
// overflow/underflow in the same cycle and leave the stack unchanged.
module pc_call_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    ptr_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             wr_s;
    logic [IW-1:0]    wr_idx_s;
    logic [IW-1:0]    top_idx_s;

    // Pointer update: push wins over pop; requests against a full/empty stack are dropped.
    always_comb begin
        ptr_nxt_s = ptr_r;
        wr_s      = 1'b0;
        if (push && !full_r) begin
            ptr_nxt_s = ptr_r + PW'(1);
            wr_s      = 1'b1;
        end else if (pop && !empty_r) begin
            ptr_nxt_s = ptr_r - PW'(1);
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    assign wr_idx_s  = IW'(ptr_r);
    assign top_idx_s = IW'(ptr_r - PW'(1));

    // Pointer and flags; flags are registered so they move on the same edge as the pointer.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            ptr_r   <= {PW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            ptr_r   <= ptr_nxt_s;
            full_r  <= (ptr_nxt_s == PW'(DEPTH));
            empty_r <= (ptr_nxt_s == {PW{1'b0}});
        end
    end

    // Storage; contents are meaningless while the pointer says so, hence no reset.
    always_ff @(posedge sysclk) begin
        if (wr_s) begin
            mem_r[wr_idx_s] <= din;
        end
    end

    assign dout      = empty_r ? {WIDTH{1'b0}} : mem_r[top_idx_s];
    assign full      = full_r;
    assign empty     = empty_r;
    assign overflow  = push & full_r;
    assign underflow = pop & empty_r;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with stall, jump, relative branch and call/return stack.
// Optional macro PC_BOUND_EN adds PC_LIMIT and the bound_hit pulse.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH_DEF,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}},
    parameter int               DEPTH     = PC_DEPTH_DEF
`ifdef PC_BOUND_EN
    ,
    parameter logic [WIDTH-1:0] PC_LIMIT  = {WIDTH{1'b1}}
`endif
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_off,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             err
`ifdef PC_BOUND_EN
    ,
    output logic             bound_hit
`endif
);

    pc_act_e          act_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] inc_s;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] pc_d_s;
    logic [WIDTH-1:0] top_s;
    logic             err_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             ovf_s;
    logic             unf_s;

    assign inc_s = pc_r + WIDTH'(STEP);

    // Priority encoder: one action per enabled cycle.
    always_comb begin
        act_s = ACT_HOLD;
        if (!en) begin
            act_s = ACT_HOLD;
        end else if (jump) begin
            act_s = ACT_JUMP;
        end else if (branch) begin
            act_s = ACT_BRANCH;
        end else if (call) begin
            act_s = ACT_CALL;
        end else if (ret) begin
            act_s = ACT_RET;
        end else begin
            act_s = ACT_INC;
        end
    end

    assign push_s = (act_s == ACT_CALL);
    assign pop_s  = (act_s == ACT_RET);

    // Next-pc mux; a rejected call/ret degrades to a plain increment.
    always_comb begin
        pc_nxt_s = pc_r;
        case (act_s)
            ACT_HOLD:   pc_nxt_s = pc_r;
            ACT_INC:    pc_nxt_s = inc_s;
            ACT_JUMP:   pc_nxt_s = jump_addr;
            ACT_BRANCH: pc_nxt_s = pc_r + branch_off;
            ACT_CALL:   pc_nxt_s = full_s ? inc_s : jump_addr;
            ACT_RET:    pc_nxt_s = empty_s ? inc_s : top_s;
            default:    pc_nxt_s = pc_r;
        endcase
    end

`ifdef PC_BOUND_EN
    logic hit_s;
    logic bound_hit_r;

    assign hit_s  = (act_s != ACT_HOLD) && (pc_nxt_s > PC_LIMIT);
    assign pc_d_s = hit_s ? RESET_VEC : pc_nxt_s;

    // Out-of-bound pulse, aligned with the substituted pc.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            bound_hit_r <= 1'b0;
        end else begin
            bound_hit_r <= hit_s;
        end
    end

    assign bound_hit = bound_hit_r;
`else
    assign pc_d_s = pc_nxt_s;
`endif

    // PC register and sticky stack error.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            pc_r  <= RESET_VEC;
            err_r <= 1'b0;
        end else begin
            pc_r  <= pc_d_s;
            err_r <= err_r | ovf_s | unf_s;
        end
    end

    pc_call_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .din       (inc_s),
        .dout      (top_s),
        .full      (full_s),
        .empty     (empty_s),
        .overflow  (ovf_s),
        .underflow (unf_s)
    );

    assign pc          = pc_r;
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign err         = err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (WIDTH=8, STEP=1, RESET_VEC=0, DEPTH=4, default build).
module tb_pc_sequencer;

    logic       sysclk;
    logic       rst_n;
    logic       en;
    logic       jump;
    logic [7:0] jump_addr;
    logic       branch;
    logic [7:0] branch_off;
    logic       call;
    logic       ret;
    logic [7:0] pc;
    logic       stack_full;
    logic       stack_empty;
    logic       err;

    int errors = 0;
    int checks = 0;

    // expected {pc, full, empty, err} per edge, with a label for reporting
    logic [10:0] exp_q[$];
    string       name_q[$];

    pc_sequencer #(
        .WIDTH     (8),
        .STEP      (1),
        .RESET_VEC (8'h00),
        .DEPTH     (4)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .en          (en),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .branch      (branch),
        .branch_off  (branch_off),
        .call        (call),
        .ret         (ret),
        .pc          (pc),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err         (err)
    );

    initial begin
        sysclk = 1'b0;
        forever #10 sysclk = ~sysclk;
    end

    // Drive one cycle's inputs at the falling edge and queue the state expected after the next rising edge.
    task automatic step(input logic r, input logic e, input logic j, input logic [7:0] ja,
                        input logic b, input logic [7:0] bo, input logic c, input logic rt,
                        input logic [7:0] epc, input logic ef, input logic ee, input logic eerr,
                        input string nm);
        @(negedge sysclk);
        rst_n = r; en = e; jump = j; jump_addr = ja;
        branch = b; branch_off = bo; call = c; ret = rt;
        exp_q.push_back({epc, ef, ee, eerr});
        name_q.push_back(nm);
        @(posedge sysclk);
    endtask

    // Monitor: pc updates every edge, so compare one queued entry per edge.
    initial begin
        logic [10:0] e;
        string       n;
        forever begin
            @(posedge sysclk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if ({pc, stack_full, stack_empty, err} !== e) begin
                    errors++;
                    $display("FAIL %s: got pc=%02h full=%b empty=%b err=%b, want pc=%02h full=%b empty=%b err=%b",
                             n, pc, stack_full, stack_empty, err, e[10:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; jump = 1'b0; jump_addr = 8'h00;
        branch = 1'b0; branch_off = 8'h00; call = 1'b0; ret = 1'b0;

        // reset held two edges, then free-run
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "reset0");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "reset1");
        for (int i = 1; i <= 5; i++)
            step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'(i), 1'b0, 1'b1, 1'b0, "freerun");

        // stall with jump asserted, then resume
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 1'b0, "stall");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h06, 1'b0, 1'b1, 1'b0, "resume");

        // preload near top, check wrap
        step(1'b1, 1'b1, 1'b1, 8'hFE, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0, "preload");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, "inc_ff");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "wrap");

        // jump beats branch, then backward branch
        step(1'b1, 1'b1, 1'b1, 8'h0A, 1'b0, 8'h00, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b1, 1'b0, "jump10");
        step(1'b1, 1'b1, 1'b1, 8'h28, 1'b1, 8'hFC, 1'b0, 1'b0, 8'h28, 1'b0, 1'b1, 1'b0, "jump_pri");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFC, 1'b0, 1'b0, 8'h24, 1'b0, 1'b1, 1'b0, "branch_back");

        // nested call/return
        step(1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, "jump3");
        step(1'b1, 1'b1, 1'b0, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, "call20");
        step(1'b1, 1'b1, 1'b0, 8'h30, 1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, "call30");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h21, 1'b0, 1'b0, 1'b0, "ret21");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0, "ret4");

        // call+ret together only pushes
        step(1'b1, 1'b1, 1'b0, 8'h50, 1'b0, 8'h00, 1'b1, 1'b1, 8'h50, 1'b0, 1'b0, 1'b0, "call_ret");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, "ret5");

        // overflow on the fifth call
        step(1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, "ovf_c1");
        step(1'b1, 1'b1, 1'b0, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, "ovf_c2");
        step(1'b1, 1'b1, 1'b0, 8'h30, 1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, "ovf_c3");
        step(1'b1, 1'b1, 1'b0, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, "ovf_c4");
        step(1'b1, 1'b1, 1'b0, 8'h50, 1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b1, "ovf_c5");
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0, 1'b1, "err_hold");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b1, "err_sticky");

        // reset clears err; ret on empty underflows
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, "rst_err");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, "unf");

        // reset in the middle of a call sequence
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "rst2");
        step(1'b1, 1'b1, 1'b0, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, "mid_c1");
        step(1'b1, 1'b1, 1'b0, 8'h30, 1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, "mid_c2");
        step(1'b0, 1'b1, 1'b0, 8'h70, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "mid_rst");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, "mid_unf");

        // backward branch wrapping below zero
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, "branch_wrap");

        // drain with a bound on edges
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge sysclk);
        #5;
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
